// File: rtl/game_score_level_unit.sv
// Scoring and level engine for the game loop.
// Each accepted line-elimination event adds level-weighted points to an
// N-digit BCD score. The carry ripples one digit per cycle, and the full digit
// count is always walked so the latency depends only on the level. After the
// score is updated the engine advances the line counters and the level. The
// gravity drop interval is derived combinationally from the level.
module game_score_level_unit #(
    parameter int digits_p          = 8,
    parameter int lines_per_level_p = 10,
    parameter int max_level_p       = 15,
    parameter int base_div_p        = 262143,
    parameter int step_div_p        = 16384,
    parameter int min_div_p         = 32767
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 clear_i,
    input  logic                                 lines_v_i,
    input  logic [2:0]                           lines_i,
    output logic                                 ready_o,
    output logic                                 done_o,
    output logic [digits_p*4-1:0]                score_o,
    output logic                                 saturated_o,
    output logic [$clog2(max_level_p+1)-1:0]     level_o,
    output logic [15:0]                          total_lines_o,
    output logic [19:0]                          drop_div_o
);

    localparam int lw_lp = $clog2(max_level_p + 1);
    localparam int iw_lp = $clog2(digits_p);
    // The in-level counter must hold (lines_per_level_p - 1) + 4 before it wraps.
    localparam int cw_lp = $clog2(lines_per_level_p + 5);

    typedef enum logic [2:0] {
        eIdle  = 3'd0,
        eAdd   = 3'd1,
        eCarry = 3'd2,
        eLevel = 3'd3,
        eDone  = 3'd4
    } state_t;

    state_t                     state_reg, state_next;
    logic [digits_p-1:0][3:0]   score_reg, score_next;
    logic                       carry_reg, carry_next;
    logic [iw_lp-1:0]           idx_reg, idx_next;
    logic [lw_lp-1:0]           rep_reg, rep_next;
    logic [2:0]                 lines_reg, lines_next;
    logic [3:0]                 points_reg, points_next;
    logic                       sat_reg, sat_next;
    logic [lw_lp-1:0]           level_reg, level_next;
    logic [cw_lp-1:0]           cnt_reg, cnt_next;
    logic [15:0]                total_reg, total_next;

    logic                       accept;
    logic [2:0]                 lines_clamp;
    logic [3:0]                 points_lookup;
    logic [4:0]                 add_sum;
    logic [cw_lp-1:0]           cnt_sum;
    logic [16:0]                total_sum;
    logic [31:0]                lvl_step;
    logic [digits_p-1:0]        digit_nine;
    logic [digits_p-1:0][3:0]   digit_inc;
    logic [digits_p-1:0][3:0]   all_nines;

    // Per-digit BCD increment helpers used by the carry ripple and saturation.
    genvar gi;
    generate
        for (gi = 0; gi < digits_p; gi++) begin : g_digit
            assign digit_nine[gi] = (score_reg[gi] == 4'd9);
            assign digit_inc[gi]  = digit_nine[gi] ? 4'd0 : score_reg[gi] + 4'd1;
            assign all_nines[gi]  = 4'd9;
        end
    endgenerate

    assign accept      = lines_v_i & (state_reg == eIdle) & ~clear_i;
    assign lines_clamp = (lines_i > 3'd4) ? 3'd4 : lines_i;
    assign add_sum     = {1'b0, score_reg[0]} + {1'b0, points_reg};
    assign cnt_sum     = cnt_reg + cw_lp'(lines_reg);
    assign total_sum   = {1'b0, total_reg} + 17'(lines_reg);

    // Points awarded per event for 0..4 cleared lines.
    always_comb begin
        points_lookup = 4'd0;
        case (lines_clamp)
            3'd1:    points_lookup = 4'd1;
            3'd2:    points_lookup = 4'd3;
            3'd3:    points_lookup = 4'd5;
            3'd4:    points_lookup = 4'd8;
            default: points_lookup = 4'd0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= eIdle;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: score digits, ripple bookkeeping and line/level counters.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            score_reg  <= '0;
            carry_reg  <= 1'b0;
            idx_reg    <= '0;
            rep_reg    <= '0;
            lines_reg  <= '0;
            points_reg <= '0;
            sat_reg    <= 1'b0;
            level_reg  <= '0;
            cnt_reg    <= '0;
            total_reg  <= '0;
        end else begin
            score_reg  <= score_next;
            carry_reg  <= carry_next;
            idx_reg    <= idx_next;
            rep_reg    <= rep_next;
            lines_reg  <= lines_next;
            points_reg <= points_next;
            sat_reg    <= sat_next;
            level_reg  <= level_next;
            cnt_reg    <= cnt_next;
            total_reg  <= total_next;
        end
    end

    // Next-state, datapath updates and handshake outputs; clear_i overrides everything.
    always_comb begin
        state_next  = state_reg;
        score_next  = score_reg;
        carry_next  = carry_reg;
        idx_next    = idx_reg;
        rep_next    = rep_reg;
        lines_next  = lines_reg;
        points_next = points_reg;
        sat_next    = sat_reg;
        level_next  = level_reg;
        cnt_next    = cnt_reg;
        total_next  = total_reg;
        ready_o     = 1'b0;
        done_o      = 1'b0;

        case (state_reg)
            eIdle: begin
                ready_o = 1'b1;
                if (accept) begin
                    lines_next  = lines_clamp;
                    points_next = points_lookup;
                    // rep_reg counts the repeats still owed after the current one,
                    // so level L gives L+1 passes.
                    rep_next    = level_reg;
                    state_next  = eAdd;
                end
            end

            eAdd: begin
                carry_next = 1'b0;
                if (!sat_reg) begin
                    if (add_sum >= 5'd10) begin
                        // Low nibble of (sum - 10) equals low nibble of (sum + 6).
                        score_next[0] = add_sum[3:0] + 4'd6;
                        carry_next    = 1'b1;
                    end else begin
                        score_next[0] = add_sum[3:0];
                    end
                end
                idx_next   = iw_lp'(1);
                state_next = eCarry;
            end

            eCarry: begin
                if (!sat_reg && carry_reg) begin
                    score_next[idx_reg] = digit_inc[idx_reg];
                    carry_next          = digit_nine[idx_reg];
                end else begin
                    carry_next = 1'b0;
                end
                if (idx_reg == iw_lp'(digits_p - 1)) begin
                    // Carry out of the top digit pins the score at all nines.
                    if (!sat_reg && carry_reg && digit_nine[idx_reg]) begin
                        score_next = all_nines;
                        sat_next   = 1'b1;
                    end
                    carry_next = 1'b0;
                    if (rep_reg != '0) begin
                        rep_next   = rep_reg - lw_lp'(1);
                        state_next = eAdd;
                    end else begin
                        state_next = eLevel;
                    end
                end else begin
                    idx_next = idx_reg + iw_lp'(1);
                end
            end

            eLevel: begin
                if (cnt_sum >= cw_lp'(lines_per_level_p)) begin
                    // The counter keeps wrapping even once the level is capped.
                    cnt_next = cnt_sum - cw_lp'(lines_per_level_p);
                    if (level_reg < lw_lp'(max_level_p)) begin
                        level_next = level_reg + lw_lp'(1);
                    end
                end else begin
                    cnt_next = cnt_sum;
                end
                total_next = total_sum[16] ? 16'hFFFF : total_sum[15:0];
                state_next = eDone;
            end

            eDone: begin
                done_o     = 1'b1;
                state_next = eIdle;
            end

            default: begin
                state_next = eIdle;
            end
        endcase

        if (clear_i) begin
            state_next  = eIdle;
            score_next  = '0;
            carry_next  = 1'b0;
            idx_next    = '0;
            rep_next    = '0;
            lines_next  = '0;
            points_next = '0;
            sat_next    = 1'b0;
            level_next  = '0;
            cnt_next    = '0;
            total_next  = '0;
        end
    end

    // Drop interval: linear decrease with level, floored, computed wide to avoid underflow.
    assign lvl_step = 32'(level_reg) * 32'(step_div_p);

    always_comb begin
        if ((lvl_step >= 32'(base_div_p)) ||
            ((32'(base_div_p) - lvl_step) < 32'(min_div_p))) begin
            drop_div_o = 20'(min_div_p);
        end else begin
            drop_div_o = 20'(32'(base_div_p) - lvl_step);
        end
    end

    assign score_o       = score_reg;
    assign saturated_o   = sat_reg;
    assign level_o       = level_reg;
    assign total_lines_o = total_reg;

endmodule
